// File: rtl/pc_seq_ctrl.sv
// Fetch PC sequencer with branch redirect, interrupt drain/vector
// entry, non-nesting ISR mode and return-from-interrupt.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0020,
  parameter logic [31:0] INTR_VEC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd1,
  parameter int          DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        intr,
  input  logic        rti,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        flush,
  output logic        intr_ack,
  output logic        in_isr
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    VECTOR,
    ISR
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        intr_pend;
  logic        rti_pend;
  logic        no_acc;

  logic [31:0] pc_seq;
  logic [31:0] pc_norm;
  logic        accept;
  logic        rti_req;

  // Normal fetch-address selection and interrupt acceptance terms
  always_comb begin
    pc_seq  = pc_out + PC_STEP;
    pc_norm = pc_seq;
    if (br_taken) begin
      pc_norm = br_target;
    end else if (stall) begin
      pc_norm = pc_out;
    end
    accept  = (state == RUN) && (intr_pend || intr) &&
              !br_taken && !stall && !no_acc;
    rti_req = rti || rti_pend;
  end

  // Sequencer state, PC/EPC and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc_out    <= RESET_VEC;
      epc_out   <= 32'd0;
      flush     <= 1'b0;
      intr_ack  <= 1'b0;
      in_isr    <= 1'b0;
      intr_pend <= 1'b0;
      rti_pend  <= 1'b0;
      no_acc    <= 1'b0;
      drain_cnt <= 4'd0;
    end else begin
      flush    <= 1'b0;
      intr_ack <= 1'b0;
      if (intr) begin
        intr_pend <= 1'b1;
      end
      unique case (state)
        RUN: begin
          no_acc <= 1'b0;
          if (accept) begin
            epc_out   <= pc_out;
            intr_pend <= 1'b0;
            drain_cnt <= 4'd0;
            flush     <= 1'b1;
            state     <= DRAIN;
          end else begin
            pc_out <= pc_norm;
            flush  <= br_taken;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            pc_out   <= INTR_VEC;
            intr_ack <= 1'b1;
            state    <= VECTOR;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
            flush     <= 1'b1;
          end
        end
        VECTOR: begin
          in_isr <= 1'b1;
          state  <= ISR;
        end
        ISR: begin
          if (rti_req) begin
            if (!stall) begin
              pc_out   <= epc_out;
              in_isr   <= 1'b0;
              flush    <= 1'b1;
              no_acc   <= 1'b1;
              rti_pend <= 1'b0;
              state    <= RUN;
            end else begin
              rti_pend <= 1'b1;
            end
          end else begin
            pc_out <= pc_norm;
            flush  <= br_taken;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed plus random checks of pc_seq_ctrl against a
// behavioural model of the sequencing rules.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RV   = 32'h0000_0020;
  localparam logic [31:0] IV   = 32'h0000_0000;
  localparam logic [31:0] STEP = 32'd1;
  localparam int          DC   = 3;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, intr, rti;
  logic [31:0] br_target;
  logic [31:0] pc_out, epc_out;
  logic        flush, intr_ack, in_isr;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0 normal, 1 draining, 2 vectoring, 3 handler
  int          m_mode;
  int          m_left;
  logic [31:0] m_pc, m_epc;
  logic        m_flush, m_ack, m_isr;
  logic        m_pend, m_fresh, m_rtiw;

  pc_seq_ctrl #(
    .RESET_VEC(RV),
    .INTR_VEC(IV),
    .PC_STEP(STEP),
    .DRAIN_CYC(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .intr(intr),
    .rti(rti),
    .pc_out(pc_out),
    .epc_out(epc_out),
    .flush(flush),
    .intr_ack(intr_ack),
    .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fetch_next(input logic [31:0] pc);
    if (br_taken) return br_target;
    if (stall) return pc;
    return pc + STEP;
  endfunction

  task automatic model_step();
    logic nf, na, r;
    nf = 1'b0;
    na = 1'b0;
    if (rst) begin
      m_mode = 0; m_left = 0; m_pc = RV; m_epc = 0;
      m_isr = 0; m_pend = 0; m_fresh = 0; m_rtiw = 0;
    end else begin
      case (m_mode)
        0: begin
          if ((m_pend || intr) && !br_taken && !stall && !m_fresh) begin
            m_epc = m_pc; m_pend = 0; m_mode = 1; m_left = DC; nf = 1;
          end else begin
            if (intr) m_pend = 1;
            m_pc = fetch_next(m_pc);
            nf = br_taken;
          end
          m_fresh = 0;
        end
        1: begin
          if (intr) m_pend = 1;
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode = 2; m_pc = IV; na = 1;
          end else begin
            nf = 1;
          end
        end
        2: begin
          if (intr) m_pend = 1;
          m_mode = 3; m_isr = 1;
        end
        default: begin
          if (intr) m_pend = 1;
          r = rti || m_rtiw;
          if (r && !stall) begin
            m_pc = m_epc; m_mode = 0; m_isr = 0;
            nf = 1; m_fresh = 1; m_rtiw = 0;
          end else if (r) begin
            m_rtiw = 1;
          end else begin
            m_pc = fetch_next(m_pc);
            nf = br_taken;
          end
        end
      endcase
    end
    m_flush = nf;
    m_ack = na;
  endtask

  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [31:0] t, input logic i,
                     input logic q);
    rst = r; stall = s; br_taken = b; br_target = t;
    intr = i; rti = q;
    @(posedge clk);
    model_step();
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("epc_out", epc_out, m_epc);
    chk("flush", 32'(flush), 32'(m_flush));
    chk("intr_ack", 32'(intr_ack), 32'(m_ack));
    chk("in_isr", 32'(in_isr), 32'(m_isr));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; stall = 0; br_taken = 0; br_target = 0;
    intr = 0; rti = 0;
    m_mode = 0; m_left = 0; m_pc = 0; m_epc = 0;
    m_flush = 0; m_ack = 0; m_isr = 0;
    m_pend = 0; m_fresh = 0; m_rtiw = 0;

    // Reset state and free-running sequence
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h55, 1, 1);
    chk("rst_pc", pc_out, 32'h20);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("seq_pc", pc_out, 32'h20 + 32'(k));
      chk("seq_flush", 32'(flush), 32'h0);
    end

    // Branch beats stall, one-cycle flush
    cyc(0, 1, 1, 32'h100, 0, 0);
    chk("br_pc", pc_out, 32'h100);
    chk("br_flush", 32'(flush), 32'h1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("br_flush_end", 32'(flush), 32'h0);
    chk("rti_run_pc", pc_out, 32'h101);

    // Wrap at top of address space
    cyc(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'h0);

    // Interrupt entry from 0x30
    cyc(0, 0, 1, 32'h30, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("acc_epc", epc_out, 32'h30);
    chk("acc_pc", pc_out, 32'h30);
    chk("drain_flush0", 32'(flush), 32'h1);
    cyc(0, 1, 1, 32'h77, 0, 1);
    chk("drain_flush1", 32'(flush), 32'h1);
    chk("drain_hold", pc_out, 32'h30);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_flush2", 32'(flush), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("vec_pc", pc_out, 32'h0);
    chk("vec_ack", 32'(intr_ack), 32'h1);
    chk("vec_flush", 32'(flush), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("isr_flag", 32'(in_isr), 32'h1);
    chk("isr_ack_off", 32'(intr_ack), 32'h0);

    // Nested request held, then rti and delayed re-acceptance
    cyc(0, 0, 0, 0, 1, 0);
    chk("no_nest", 32'(in_isr), 32'h1);
    cyc(0, 0, 1, 32'h999, 0, 1);
    chk("rti_pc", pc_out, 32'h30);
    chk("rti_isr", 32'(in_isr), 32'h0);
    chk("rti_flush", 32'(flush), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fresh_pc", pc_out, 32'h31);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reacc_epc", epc_out, 32'h31);
    idle(DC + 2);

    // Stalled rti waits for stall release
    cyc(0, 1, 0, 0, 0, 1);
    chk("rti_stall", 32'(in_isr), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rti_late_pc", pc_out, 32'h31);
    idle(3);

    // Interrupt under a two-cycle stall
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("stall_noacc", 32'(flush), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_acc_epc", epc_out, 32'h34);
    chk("stall_acc_flush", 32'(flush), 32'h1);

    // Reset in the second drain cycle
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("mid_rst_pc", pc_out, 32'h20);
    chk("mid_rst_flush", 32'(flush), 32'h0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("post_rst_ack", 32'(intr_ack), 32'h0);
    end

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          $urandom,
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
